// File: rtl/calc1_port_responder_pkg.sv
// Shared definitions for the calc1 responder: command/response codes,
// FSM state encoding and datapath width.
package calc1_pkg;
   localparam int DATA_W = 32;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OP2,
      ST_EXEC,
      ST_RESP
   } state_t;
endpackage

// File: rtl/calc1_port_responder_if.sv
// Request/response bundle between the bench-side initiator (master)
// and the responder (slave).
interface calc1_port_responder_if
   import calc1_pkg::*;
#(
   parameter int CNT_W = 8
) ();
   logic [3:0]        cmd_in;
   logic [DATA_W-1:0] data_in;
   logic [1:0]        out_resp;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic [CNT_W-1:0]  drop_cnt;

   modport master (
      output cmd_in, data_in,
      input  out_resp, data_out, busy, drop_cnt
   );

   modport slave (
      input  cmd_in, data_in,
      output out_resp, data_out, busy, drop_cnt
   );
endinterface

// File: rtl/calc1_port_responder_alu.sv
// Combinational calc1 execute stage: add/sub with range errors,
// logical shifts by the low five bits of op2.
module calc1_alu
   import calc1_pkg::*;
(
   input  logic [3:0]        cmd,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   output logic [DATA_W-1:0] result,
   output logic [1:0]        resp
);
   logic [DATA_W:0] sum;

   always_comb begin
      sum    = {1'b0, op1} + {1'b0, op2};
      result = '0;
      resp   = RESP_ERR;
      case (cmd)
         CMD_ADD: begin
            if (!sum[DATA_W]) begin
               result = sum[DATA_W-1:0];
               resp   = RESP_OK;
            end
         end
         CMD_SUB: begin
            if (op2 <= op1) begin
               result = op1 - op2;
               resp   = RESP_OK;
            end
         end
         CMD_SHL: begin
            result = op1 << op2[4:0];
            resp   = RESP_OK;
         end
         CMD_SHR: begin
            result = op1 >> op2[4:0];
            resp   = RESP_OK;
         end
         default: begin
            result = '0;
            resp   = RESP_ERR;
         end
      endcase
   end
endmodule

// File: rtl/calc1_port_responder.sv
// calc1 device end: IDLE -> OP2 -> EXEC -> RESP sequencer with one
// outstanding transaction, registered one-cycle response and drop counter.
module calc1_port_responder
   import calc1_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                  c_clk,
   input  logic                  reset_n,
   calc1_port_responder_if.slave bus
);
   state_t            state;
   logic [3:0]        cmd_reg;
   logic [DATA_W-1:0] op1_reg;
   logic [DATA_W-1:0] op2_reg;
   logic [DATA_W-1:0] res_reg;
   logic [1:0]        res_resp_reg;
   logic [1:0]        out_resp_reg;
   logic [DATA_W-1:0] data_out_reg;
   logic              busy_reg;
   logic [CNT_W-1:0]  drop_cnt_reg;

   logic [DATA_W-1:0] alu_result;
   logic [1:0]        alu_resp;

   calc1_alu u_alu (
      .cmd    (cmd_reg),
      .op1    (op1_reg),
      .op2    (op2_reg),
      .result (alu_result),
      .resp   (alu_resp)
   );

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         cmd_reg      <= CMD_NOP;
         op1_reg      <= '0;
         op2_reg      <= '0;
         res_reg      <= '0;
         res_resp_reg <= RESP_NONE;
         out_resp_reg <= RESP_NONE;
         data_out_reg <= '0;
         busy_reg     <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         out_resp_reg <= RESP_NONE;
         data_out_reg <= '0;
         case (state)
            ST_IDLE: begin
               // busy stays up through the response cycle and only drops
               // on the first idle edge with no new command
               if (bus.cmd_in != CMD_NOP) begin
                  cmd_reg  <= bus.cmd_in;
                  op1_reg  <= bus.data_in;
                  busy_reg <= 1'b1;
                  state    <= ST_OP2;
               end else begin
                  busy_reg <= 1'b0;
               end
            end
            ST_OP2: begin
               op2_reg <= bus.data_in;
               state   <= ST_EXEC;
            end
            ST_EXEC: begin
               res_reg      <= alu_result;
               res_resp_reg <= alu_resp;
               state        <= ST_RESP;
            end
            ST_RESP: begin
               out_resp_reg <= res_resp_reg;
               data_out_reg <= res_reg;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if ((state == ST_EXEC || state == ST_RESP) && bus.cmd_in != CMD_NOP
             && drop_cnt_reg != {CNT_W{1'b1}})
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
   end

   assign bus.out_resp = out_resp_reg;
   assign bus.data_out = data_out_reg;
   assign bus.busy     = busy_reg;
   assign bus.drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed scoreboard bench for calc1_port_responder: expected responses are
// queued when a command is driven and checked, cycle-exact, when they appear.
module tb_calc1_port_responder;
   logic c_clk   = 1'b0;
   logic reset_n = 1'b1;
   int   cyc     = 0;
   int   n_vec   = 0;
   int   n_miss  = 0;
   int   exp_drop = 0;
   logic prev_valid = 1'b0;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      int          at_cyc;
   } exp_t;
   exp_t sb_q[$];

   calc1_port_responder_if #(.CNT_W(8)) bus ();

   calc1_port_responder #(.CNT_W(8)) dut (
      .c_clk   (c_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 c_clk = ~c_clk;
   always @(posedge c_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called just after a clock edge; returns just after edge T+3 so the next
   // call lands its command on edge T+4 (back-to-back rate).
   task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] er, input logic [31:0] ed, input bit drop);
      exp_t e;
      e.resp   = er;
      e.data   = ed;
      e.at_cyc = cyc + 4;
      sb_q.push_back(e);
      bus.cmd_in  = c;
      bus.data_in = a;
      @(posedge c_clk); #1;
      bus.cmd_in  = 4'd0;
      bus.data_in = b;
      @(posedge c_clk); #1;
      bus.cmd_in  = drop ? 4'd1 : 4'd0;
      bus.data_in = 32'hDEAD_BEEF;
      @(posedge c_clk); #1;
      @(posedge c_clk); #1;
      bus.cmd_in  = 4'd0;
      bus.data_in = 32'd0;
      if (drop) exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
   endtask

   always @(negedge c_clk) begin
      if (reset_n) begin
         if (bus.out_resp != 2'd0) begin
            if (sb_q.size() == 0) begin
               check("unexpected_resp", {30'd0, bus.out_resp}, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("resp_cycle", 32'(cyc), 32'(e.at_cyc));
               check("resp_code", {30'd0, bus.out_resp}, {30'd0, e.resp});
               check("resp_data", bus.data_out, e.data);
            end
            prev_valid <= 1'b1;
         end else if (prev_valid) begin
            check("clear_data", bus.data_out, 32'd0);
            prev_valid <= 1'b0;
         end
      end else begin
         prev_valid <= 1'b0;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_in  = 4'd0;
      bus.data_in = 32'd0;
      #1 reset_n = 1'b0;
      #3;
      check("rst_resp", {30'd0, bus.out_resp}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      repeat (2) @(posedge c_clk);
      @(negedge c_clk); #2 reset_n = 1'b1;
      @(negedge c_clk);
      check("rst_data", bus.data_out, 32'd0);
      check("rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
      @(posedge c_clk); #1;

      // busy timing on a single transaction
      send(4'd1, 32'd10, 32'd20, 2'd1, 32'd30, 1'b0);
      check("busy_at_t3", {31'd0, bus.busy}, 32'd1);
      @(posedge c_clk); #1;
      check("busy_after_t4", {31'd0, bus.busy}, 32'd0);

      for (int k = 0; k <= 30; k++)
         send(4'd1, 32'd1 << k, 32'd0, 2'd1, 32'd1 << k, 1'b0);

      send(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0, 1'b0);
      send(4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, 1'b0);
      send(4'd2, 32'd5, 32'd7, 2'd2, 32'd0, 1'b0);
      send(4'd2, 32'd7, 32'd5, 2'd1, 32'd2, 1'b0);
      send(4'd2, 32'd9, 32'd9, 2'd1, 32'd0, 1'b0);
      send(4'd5, 32'd1, 32'h0000_0023, 2'd1, 32'd8, 1'b0);
      send(4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1, 1'b0);
      send(4'd6, 32'h1234_5678, 32'hFFFF_FFE0, 2'd1, 32'h1234_5678, 1'b0);
      send(4'd4, 32'd1, 32'd1, 2'd2, 32'd0, 1'b0);
      send(4'd15, 32'd1, 32'd1, 2'd2, 32'd0, 1'b0);

      send(4'd1, 32'd100, 32'd23, 2'd1, 32'd123, 1'b1);
      check("drop_two", {24'd0, bus.drop_cnt}, 32'(exp_drop));

      // reset while in EXEC: no response, outputs back to reset values at once
      bus.cmd_in  = 4'd1;
      bus.data_in = 32'd40;
      @(posedge c_clk); #1;
      bus.cmd_in  = 4'd0;
      bus.data_in = 32'd2;
      @(posedge c_clk); #1;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_resp", {30'd0, bus.out_resp}, 32'd0);
      check("midrst_drop", {24'd0, bus.drop_cnt}, 32'd0);
      exp_drop = 0;
      repeat (2) @(posedge c_clk);
      @(negedge c_clk); #2 reset_n = 1'b1;
      @(posedge c_clk); #1;
      send(4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 1'b0);

      for (int i = 0; i < 150; i++) begin
         send(4'd1, 32'(i), 32'(i), 2'd1, 32'(2 * i), 1'b1);
         if (i == 126) check("drop_254", {24'd0, bus.drop_cnt}, 32'(exp_drop));
         if (i == 127) check("drop_255", {24'd0, bus.drop_cnt}, 32'(exp_drop));
      end
      check("drop_sat", {24'd0, bus.drop_cnt}, 32'd255);

      repeat (6) @(posedge c_clk);
      #1;
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
